// File: rtl/fifo_order_checker_pkg.sv
// Shared types for the in-order FIFO scoreboard.
package fifoOrderCheckerPkg;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_MISMATCH,
        ERR_UNDERFLOW,
        ERR_OVERFLOW
    } errorCode_t;

    typedef enum logic [1:0] {
        S_RUN,
        S_FAIL,
        S_DONE
    } state_t;

endpackage

// File: rtl/fifo_order_checker_fifo.sv
// Single-write single-read queue with wrap-bit pointers.
// DEPTH need not be a power of two.
module fifoW1R1
    import fifoOrderCheckerPkg::*;
#(
    parameter int WIDTH              = 8,
    parameter int DEPTH              = 16,
    parameter int FLOPS_NOT_MEM      = 1,
    parameter int FORCEKEEP_NENTRIES = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cg,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_nEntries
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = IW + 1;
    localparam int NW = $clog2(DEPTH + 1);

    // Index wraps DEPTH-1 -> 0 and flips the wrap bit.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p[IW-1:0] == IW'(DEPTH - 1)) begin
            return {~p[PW-1], {IW{1'b0}}};
        end
        return p + PW'(1);
    endfunction

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             full, empty, wr_en, rd_en;

    always_comb begin
        full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1])
             && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        rd_en = i_cg && i_ready && !empty;
        // A pop in the same cycle frees the slot a full write needs.
        wr_en = i_cg && i_valid && (!full || rd_en);
        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[IW-1:0]] = i_data;
        end
    end

    assign o_ready = !full;
    assign o_valid = !empty;
    assign o_data  = mem_q[rd_ptr_q[IW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    if (FLOPS_NOT_MEM != 0) begin : g_flops
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else begin
                mem_q <= mem_d;
            end
        end
    end else begin : g_mem
        always_ff @(posedge i_clk) begin
            mem_q <= mem_d;
        end
    end

    if (FORCEKEEP_NENTRIES != 0) begin : g_cnt
        logic [NW-1:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q + NW'(wr_en) - NW'(rd_en);
        end
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
        assign o_nEntries = cnt_q;
    end else begin : g_ptr
        logic [NW-1:0] wr_i, rd_i;
        always_comb begin
            wr_i = NW'(wr_ptr_q[IW-1:0]);
            rd_i = NW'(rd_ptr_q[IW-1:0]);
            if (wr_ptr_q[PW-1] == rd_ptr_q[PW-1]) begin
                o_nEntries = wr_i - rd_i;
            end else begin
                o_nEntries = NW'(DEPTH) + wr_i - rd_i;
            end
        end
    end

endmodule

// File: rtl/fifo_order_checker.sv
// In-order scoreboard for a single-clock FIFO-like DUT:
// counts events, records the first error, gives a verdict.
module fifo_order_checker
    import fifoOrderCheckerPkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cg,
    input  logic                       i_pushed,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_popped,
    input  logic [WIDTH-1:0]           i_rdata,
    input  logic                       i_finish,
    output logic [$clog2(DEPTH+1)-1:0] o_nExpected,
    output logic [CNT_W-1:0]           o_nPushed,
    output logic [CNT_W-1:0]           o_nPopped,
    output logic [CNT_W-1:0]           o_nMismatch,
    output logic                       o_error,
    output logic [1:0]                 o_errorCode,
    output logic [WIDTH-1:0]           o_errorExpected,
    output logic [WIDTH-1:0]           o_errorActual,
    output logic                       o_done,
    output logic                       o_pass
);

    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NW-1:0]    n_entries, nexp_next;
    logic             q_ready, q_valid;
    logic [WIDTH-1:0] q_head;

    logic ev_en, push, pop, fin;
    logic underflow, overflow, mismatch, err_any;
    logic push_acc, pop_acc;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] npushed_q, npushed_d;
    logic [CNT_W-1:0] npopped_q, npopped_d;
    logic [CNT_W-1:0] nmis_q, nmis_d;
    logic             error_q, error_d;
    errorCode_t       code_q, code_d;
    logic [WIDTH-1:0] eexp_q, eexp_d;
    logic [WIDTH-1:0] eact_q, eact_d;
    logic             pass_q, pass_d;

    always_comb begin
        ev_en = i_cg && (state_q != S_DONE);
        push  = ev_en && i_pushed;
        pop   = ev_en && i_popped;
        fin   = ev_en && i_finish;

        // A same-cycle push never satisfies a pop on an empty queue.
        underflow = pop && !q_valid;
        overflow  = push && !q_ready && !pop;
        mismatch  = pop && q_valid && (q_head != i_rdata);
        err_any   = underflow || overflow || mismatch;
        push_acc  = push && !overflow;
        pop_acc   = pop && q_valid;

        npushed_d = npushed_q;
        npopped_d = npopped_q;
        nmis_d    = nmis_q;
        if (push && npushed_q != CNT_MAX) begin
            npushed_d = npushed_q + CNT_W'(1);
        end
        if (pop && npopped_q != CNT_MAX) begin
            npopped_d = npopped_q + CNT_W'(1);
        end
        if (mismatch && nmis_q != CNT_MAX) begin
            nmis_d = nmis_q + CNT_W'(1);
        end

        error_d = error_q || err_any;
        code_d  = code_q;
        eexp_d  = eexp_q;
        eact_d  = eact_q;
        if (err_any && !error_q) begin
            unique case (1'b1)
                mismatch:  code_d = ERR_MISMATCH;
                underflow: code_d = ERR_UNDERFLOW;
                default:   code_d = ERR_OVERFLOW;
            endcase
            eexp_d = underflow ? '0 : q_head;
            eact_d = overflow ? i_wdata : i_rdata;
        end

        nexp_next = n_entries + NW'(push_acc) - NW'(pop_acc);

        state_d = state_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_RUN: begin
                if (fin) begin
                    state_d = S_DONE;
                end else if (err_any) begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                if (fin) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = state_q;
        endcase
        if (fin) begin
            pass_d = !error_d && (nexp_next == '0)
                  && (npushed_d == npopped_d);
        end
    end

    fifoW1R1 #(
        .WIDTH             (WIDTH),
        .DEPTH             (DEPTH),
        .FLOPS_NOT_MEM     (1),
        .FORCEKEEP_NENTRIES(0)
    ) u_queue (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_cg      (ev_en),
        .i_valid   (push_acc),
        .o_ready   (q_ready),
        .i_data    (i_wdata),
        .o_valid   (q_valid),
        .i_ready   (pop_acc),
        .o_data    (q_head),
        .o_nEntries(n_entries)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_RUN;
            npushed_q <= '0;
            npopped_q <= '0;
            nmis_q    <= '0;
            error_q   <= 1'b0;
            code_q    <= ERR_NONE;
            eexp_q    <= '0;
            eact_q    <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            npushed_q <= npushed_d;
            npopped_q <= npopped_d;
            nmis_q    <= nmis_d;
            error_q   <= error_d;
            code_q    <= code_d;
            eexp_q    <= eexp_d;
            eact_q    <= eact_d;
            pass_q    <= pass_d;
        end
    end

    assign o_nExpected     = n_entries;
    assign o_nPushed       = npushed_q;
    assign o_nPopped       = npopped_q;
    assign o_nMismatch     = nmis_q;
    assign o_error         = error_q;
    assign o_errorCode     = code_q;
    assign o_errorExpected = eexp_q;
    assign o_errorActual   = eact_q;
    assign o_done          = (state_q == S_DONE);
    assign o_pass          = pass_q;

endmodule

// File: tb/tb_fifo_order_checker.sv
// Bench for fifo_order_checker: vector table, directed
// sequences and random traffic against a queue model.
module tb_fifo_order_checker;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, cg, pushed, popped, fin;
    logic [W-1:0] wdata, rdata;
    logic [2:0]   n_exp;
    logic [CW-1:0] n_push, n_pop, n_mis;
    logic         err;
    logic [1:0]   ecode;
    logic [W-1:0] eexp, eact;
    logic         done, pass;

    fifo_order_checker #(
        .WIDTH(W),
        .DEPTH(D),
        .CNT_W(CW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cg           (cg),
        .i_pushed       (pushed),
        .i_wdata        (wdata),
        .i_popped       (popped),
        .i_rdata        (rdata),
        .i_finish       (fin),
        .o_nExpected    (n_exp),
        .o_nPushed      (n_push),
        .o_nPopped      (n_pop),
        .o_nMismatch    (n_mis),
        .o_error        (err),
        .o_errorCode    (ecode),
        .o_errorExpected(eexp),
        .o_errorActual  (eact),
        .o_done         (done),
        .o_pass         (pass)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mq[$];
    int m_push, m_pop, m_mis, m_code, m_eexp, m_eact;
    bit m_err, m_done, m_pass;

    typedef struct {
        bit r, c, p;
        logic [7:0] wd;
        bit po;
        logic [7:0] rd;
        bit f;
        int nexp, npu, npo, nmi;
        bit e;
        int code, ee, ea;
        bit dn, ps;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_push = 0; m_pop = 0; m_mis = 0;
        m_code = 0; m_eexp = 0; m_eact = 0;
        m_err = 0; m_done = 0; m_pass = 0;
    endtask

    task automatic model_step();
        int head0;
        bit und, ovf, mis;
        if (rst) begin
            model_reset();
            return;
        end
        if (!cg || m_done) return;
        head0 = (mq.size() > 0) ? int'(mq[0]) : 0;
        und = popped && mq.size() == 0;
        ovf = pushed && mq.size() == D && !popped;
        mis = popped && mq.size() > 0 && mq[0] != rdata;
        if (popped && mq.size() > 0) void'(mq.pop_front());
        if (pushed && !ovf) mq.push_back(wdata);
        if (pushed && m_push < 65535) m_push++;
        if (popped && m_pop < 65535) m_pop++;
        if (mis && m_mis < 65535) m_mis++;
        if ((und || ovf || mis) && !m_err) begin
            m_code = mis ? 1 : (und ? 2 : 3);
            m_eexp = und ? 0 : head0;
            m_eact = ovf ? int'(wdata) : int'(rdata);
        end
        m_err = m_err || und || ovf || mis;
        if (fin) begin
            m_done = 1;
            m_pass = !m_err && mq.size() == 0
                  && m_push == m_pop;
        end
    endtask

    task automatic cyc(bit r, bit c, bit p, logic [7:0] wd,
                       bit po, logic [7:0] rd, bit f);
        rst = r; cg = c; pushed = p; wdata = wd;
        popped = po; rdata = rd; fin = f;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".nExpected"}, 32'(n_exp), mq.size());
        chk({tag, ".nPushed"}, 32'(n_push), m_push);
        chk({tag, ".nPopped"}, 32'(n_pop), m_pop);
        chk({tag, ".nMismatch"}, 32'(n_mis), m_mis);
        chk({tag, ".error"}, 32'(err), 32'(m_err));
        chk({tag, ".errorCode"}, 32'(ecode), m_code);
        chk({tag, ".errorExpected"}, 32'(eexp), m_eexp);
        chk({tag, ".errorActual"}, 32'(eact), m_eact);
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".pass"}, 32'(pass), 32'(m_pass));
    endtask

    task automatic add(bit r, bit c, bit p, logic [7:0] wd,
                       bit po, logic [7:0] rd, bit f,
                       int nexp, int npu, int npo, int nmi,
                       bit e, int code, int ee, int ea,
                       bit dn, bit ps);
        vec_t v;
        v = '{r, c, p, wd, po, rd, f, nexp, npu, npo, nmi,
              e, code, ee, ea, dn, ps};
        tbl.push_back(v);
    endtask

    task automatic add_rst();
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; cg = 0; pushed = 0; popped = 0; fin = 0;
        wdata = 0; rdata = 0;
        model_reset();

        // in-order pass
        add_rst();
        add(0,1,1,8'h11,0,0,0, 1,1,0,0, 0,0,0,0, 0,0);
        add(0,1,1,8'h22,0,0,0, 2,2,0,0, 0,0,0,0, 0,0);
        add(0,1,1,8'h33,0,0,0, 3,3,0,0, 0,0,0,0, 0,0);
        add(0,1,0,0,1,8'h11,0, 2,3,1,0, 0,0,0,0, 0,0);
        add(0,1,0,0,1,8'h22,0, 1,3,2,0, 0,0,0,0, 0,0);
        add(0,1,0,0,1,8'h33,0, 0,3,3,0, 0,0,0,0, 0,0);
        add(0,1,0,0,0,0,1,     0,3,3,0, 0,0,0,0, 1,1);
        add(0,1,1,8'h44,1,1,0, 0,3,3,0, 0,0,0,0, 1,1);
        // mismatch
        add_rst();
        add(0,1,1,8'hAA,0,0,0, 1,1,0,0, 0,0,0,0, 0,0);
        add(0,1,0,0,1,8'hAB,0, 0,1,1,1, 1,1,8'hAA,8'hAB, 0,0);
        add(0,1,0,0,0,0,1,     0,1,1,1, 1,1,8'hAA,8'hAB, 1,0);
        // underflow with same-cycle push
        add_rst();
        add(0,1,1,8'h05,1,8'h07,0, 1,1,1,0, 1,2,0,8'h07, 0,0);
        // overflow, then push+pop while full and drain
        add_rst();
        add(0,1,1,8'h01,0,0,0, 1,1,0,0, 0,0,0,0, 0,0);
        add(0,1,1,8'h02,0,0,0, 2,2,0,0, 0,0,0,0, 0,0);
        add(0,1,1,8'h03,0,0,0, 3,3,0,0, 0,0,0,0, 0,0);
        add(0,1,1,8'h04,0,0,0, 4,4,0,0, 0,0,0,0, 0,0);
        add(0,1,1,8'h05,0,0,0, 4,5,0,0, 1,3,1,5, 0,0);
        add(0,1,1,8'h06,1,8'h01,0, 4,6,1,0, 1,3,1,5, 0,0);
        add(0,1,0,0,1,8'h02,0, 3,6,2,0, 1,3,1,5, 0,0);
        add(0,1,0,0,1,8'h03,0, 2,6,3,0, 1,3,1,5, 0,0);
        add(0,1,0,0,1,8'h04,0, 1,6,4,0, 1,3,1,5, 0,0);
        add(0,1,0,0,1,8'h06,0, 0,6,5,0, 1,3,1,5, 0,0);
        add(0,1,0,0,0,0,1,     0,6,5,0, 1,3,1,5, 1,0);

        foreach (tbl[i]) begin
            vec_t v;
            string t;
            v = tbl[i];
            t = $sformatf("vec%0d", i);
            cyc(v.r, v.c, v.p, v.wd, v.po, v.rd, v.f);
            chk({t, ".nExpected"}, 32'(n_exp), v.nexp);
            chk({t, ".nPushed"}, 32'(n_push), v.npu);
            chk({t, ".nPopped"}, 32'(n_pop), v.npo);
            chk({t, ".nMismatch"}, 32'(n_mis), v.nmi);
            chk({t, ".error"}, 32'(err), 32'(v.e));
            chk({t, ".errorCode"}, 32'(ecode), v.code);
            chk({t, ".errorExpected"}, 32'(eexp), v.ee);
            chk({t, ".errorActual"}, 32'(eact), v.ea);
            chk({t, ".done"}, 32'(done), 32'(v.dn));
            chk({t, ".pass"}, 32'(pass), 32'(v.ps));
        end

        // clock gate low: events and finish ignored
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 8'h09, 0, 0, 0);
        cyc(0, 0, 1, 8'h08, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h09, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("cg.nPushed", 32'(n_push), 1);
        chk("cg.nPopped", 32'(n_pop), 0);
        chk("cg.nExpected", 32'(n_exp), 1);
        chk("cg.done", 32'(done), 0);
        cyc(0, 1, 0, 0, 1, 8'h09, 0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        chk("cg.pass", 32'(pass), 1);
        check_model("cg");

        // wrap traffic, then reset mid-stream
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 8'h01, 0, 0, 0);       check_model("w1");
        cyc(0, 1, 1, 8'h02, 0, 0, 0);       check_model("w2");
        cyc(0, 1, 1, 8'h03, 0, 0, 0);       check_model("w3");
        cyc(0, 1, 0, 0, 1, 8'h01, 0);       check_model("w4");
        cyc(0, 1, 1, 8'h04, 0, 0, 0);       check_model("w5");
        cyc(0, 1, 1, 8'h05, 1, 8'h02, 0);   check_model("w6");
        cyc(0, 1, 1, 8'h06, 0, 0, 0);       check_model("w7");
        cyc(0, 1, 1, 8'h07, 1, 8'h03, 0);   check_model("w8");
        cyc(0, 1, 0, 0, 1, 8'h04, 0);       check_model("w9");
        cyc(0, 1, 0, 0, 1, 8'h05, 0);       check_model("w10");
        cyc(0, 1, 0, 0, 1, 8'h06, 0);       check_model("w11");
        chk("wrap.nPushed", 32'(n_push), 7);
        chk("wrap.nPopped", 32'(n_pop), 6);
        chk("wrap.nExpected", 32'(n_exp), 1);
        cyc(1, 1, 1, 8'hAA, 1, 8'hBB, 1);
        chk("rst.nExpected", 32'(n_exp), 0);
        chk("rst.nPushed", 32'(n_push), 0);
        chk("rst.nPopped", 32'(n_pop), 0);
        chk("rst.error", 32'(err), 0);
        chk("rst.done", 32'(done), 0);
        cyc(0, 1, 1, 8'h03, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 8'h03, 0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        chk("fresh.done", 32'(done), 1);
        chk("fresh.pass", 32'(pass), 1);

        // random traffic against the queue model
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit r, c, p, po, f;
            logic [7:0] wd, rd;
            r  = ($urandom_range(0, 199) == 0)
              || (m_done && $urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 9) != 0);
            p  = $urandom_range(0, 1) == 1;
            po = $urandom_range(0, 1) == 1;
            wd = 8'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 15) != 0)
                rd = mq[0];
            else
                rd = 8'($urandom);
            f  = ($urandom_range(0, 99) == 0);
            cyc(r, c, p, wd, po, rd, f);
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
